// File: rtl/nutrient_scan_ctrl_if.sv
// ADC request/acknowledge bus shared between the scan controller (master) and the ADC (slave).
interface nutrient_scan_ctrl_if #(
  parameter int unsigned DATA_W = 12
) ();
  logic              adc_req;
  logic [1:0]        adc_ch;
  logic              adc_ack;
  logic [DATA_W-1:0] adc_data;

  modport master (output adc_req, adc_ch, input adc_ack, adc_data);
  modport slave  (input adc_req, adc_ch, output adc_ack, adc_data);
endinterface

// File: rtl/nutrient_scan_ctrl.sv
// Round-robin N/P/K sampler over one shared ADC, with hysteresis thresholds, multi-round
// confirmation of deficiency flags and a sticky handshake-timeout flag.
module nutrient_scan_ctrl #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_en,
  input  logic [DATA_W-1:0]    thr_N,
  input  logic [DATA_W-1:0]    thr_P,
  input  logic [DATA_W-1:0]    thr_K,
  input  logic [DATA_W-1:0]    hyst,
  input  logic                 err_clr,
  nutrient_scan_ctrl_if.master adc,
  output logic                 en_N,
  output logic                 en_P,
  output logic                 en_K,
  output logic                 scan_done,
  output logic                 adc_err
);

  localparam int unsigned TickW = $clog2(SCAN_DIV + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StReq, StWaitAck, StEval, StWaitTick} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic              req_q, req_d;
  logic [1:0]        adc_ch_q, adc_ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [2:0]        en_q, en_d;
  logic [3:0]        cnt_q [3];
  logic [3:0]        cnt_d [3];
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] thr_sel;
  logic [DATA_W:0]   thr_sum;
  logic [DATA_W-1:0] rec_lim;
  logic              is_low, is_rec, qual, round_end;
  logic [3:0]        cnt_nx;

  always_comb begin
    case (ch_q)
      2'd0:    thr_sel = thr_N;
      2'd1:    thr_sel = thr_P;
      default: thr_sel = thr_K;
    endcase
    // Recovery limit saturates at full scale so a high threshold can still clear.
    thr_sum = {1'b0, thr_sel} + {1'b0, hyst};
    rec_lim = thr_sum[DATA_W] ? {DATA_W{1'b1}} : thr_sum[DATA_W-1:0];
    is_low  = data_q < thr_sel;
    is_rec  = data_q >= rec_lim;
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    req_d     = req_q;
    adc_ch_d  = adc_ch_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    tick_d    = tick_q;
    en_d      = en_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = err_clr ? 1'b0 : err_q;
    round_end = 1'b0;
    qual      = 1'b0;
    cnt_nx    = cnt_q[ch_q] + 4'd1;

    case (state_q)
      StIdle: begin
        if (start_en) begin
          ch_d    = 2'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        req_d    = 1'b1;
        adc_ch_d = ch_q;
        tmo_d    = '0;
        state_d  = StWaitAck;
      end
      StWaitAck: begin
        if (adc.adc_ack) begin
          data_d  = adc.adc_data;
          req_d   = 1'b0;
          state_d = StEval;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          req_d = 1'b0;
          err_d = 1'b1;
          if (ch_q == 2'd2) begin
            round_end = 1'b1;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = StReq;
          end
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StEval: begin
        qual = en_q[ch_q] ? is_rec : is_low;
        if (!qual) begin
          cnt_d[ch_q] = '0;
        end else if (cnt_nx == 4'(CONFIRM)) begin
          en_d[ch_q]  = ~en_q[ch_q];
          cnt_d[ch_q] = '0;
        end else begin
          cnt_d[ch_q] = cnt_nx;
        end
        if (ch_q == 2'd2) begin
          round_end = 1'b1;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = StReq;
        end
      end
      StWaitTick: begin
        if (!start_en) begin
          tick_d  = '0;
          state_d = StIdle;
        end else if (tick_q == TickW'(SCAN_DIV - 1)) begin
          tick_d  = '0;
          ch_d    = 2'd0;
          state_d = StReq;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (round_end) begin
      done_d  = 1'b1;
      tick_d  = '0;
      state_d = start_en ? StWaitTick : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      req_q    <= 1'b0;
      adc_ch_q <= '0;
      data_q   <= '0;
      tmo_q    <= '0;
      tick_q   <= '0;
      en_q     <= '0;
      cnt_q    <= '{default: '0};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      req_q    <= req_d;
      adc_ch_q <= adc_ch_d;
      data_q   <= data_d;
      tmo_q    <= tmo_d;
      tick_q   <= tick_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign adc.adc_req = req_q;
  assign adc.adc_ch  = adc_ch_q;
  assign en_N        = en_q[0];
  assign en_P        = en_q[1];
  assign en_K        = en_q[2];
  assign scan_done   = done_q;
  assign adc_err     = err_q;

endmodule

// File: tb/tb_nutrient_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected channel order and end-of-round flags,
// a monitor compares them as requests and scan_done pulses appear.
module tb_nutrient_scan_ctrl;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned SCAN_DIV = 16;
  localparam int unsigned CONFIRM  = 3;
  localparam int unsigned TIMEOUT  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_en = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] thr_N = 12'd500;
  logic [DATA_W-1:0] thr_P = 12'd500;
  logic [DATA_W-1:0] thr_K = 12'd500;
  logic [DATA_W-1:0] hyst  = 12'd50;
  logic              en_N, en_P, en_K, scan_done, adc_err;

  nutrient_scan_ctrl_if #(.DATA_W(DATA_W)) adc_bus ();

  nutrient_scan_ctrl #(
    .DATA_W  (DATA_W),
    .SCAN_DIV(SCAN_DIV),
    .CONFIRM (CONFIRM),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_en (start_en),
    .thr_N    (thr_N),
    .thr_P    (thr_P),
    .thr_K    (thr_K),
    .hyst     (hyst),
    .err_clr  (err_clr),
    .adc      (adc_bus),
    .en_N     (en_N),
    .en_P     (en_P),
    .en_K     (en_K),
    .scan_done(scan_done),
    .adc_err  (adc_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] val [4];
  int                mute_ch  = -1;
  bit                model_en = 1'b1;
  int                age      = 0;
  int                exp_ch_q[$];
  logic [3:0]        exp_flag_q[$];   // {adc_err, en_K, en_P, en_N}
  logic              prev_req = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ADC model: ack with the channel's value two cycles after req is seen high.
  initial begin
    adc_bus.adc_ack  = 1'b0;
    adc_bus.adc_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        if (adc_bus.adc_ack) begin
          adc_bus.adc_ack = 1'b0;
          age = 0;
        end else if (adc_bus.adc_req && int'(adc_bus.adc_ch) != mute_ch) begin
          age++;
          if (age == 2) begin
            adc_bus.adc_ack  = 1'b1;
            adc_bus.adc_data = val[adc_bus.adc_ch];
          end
        end else begin
          age = 0;
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (adc_bus.adc_req && !prev_req) begin
        if (exp_ch_q.size() == 0) fail_now("unexpected_req");
        else chk("adc_ch", int'(adc_bus.adc_ch), exp_ch_q.pop_front());
      end
      if (scan_done) begin
        if (exp_flag_q.size() == 0) fail_now("unexpected_scan_done");
        else chk("round_flags", int'({adc_err, en_K, en_P, en_N}), int'(exp_flag_q.pop_front()));
      end
      prev_req = adc_bus.adc_req;
    end
  end

  task automatic push_round(input int vn, input int vp, input int vk, input logic [3:0] exp);
    val[0] = DATA_W'(vn);
    val[1] = DATA_W'(vp);
    val[2] = DATA_W'(vk);
    exp_ch_q.push_back(0);
    exp_ch_q.push_back(1);
    exp_ch_q.push_back(2);
    exp_flag_q.push_back(exp);
  endtask

  task automatic wait_done();
    int n;
    @(negedge clk);
    n = 1;
    while (!scan_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!scan_done) fail_now("round_timeout");
  endtask

  task automatic round(input int vn, input int vp, input int vk, input logic [3:0] exp);
    push_round(vn, vp, vk, exp);
    wait_done();
  endtask

  initial begin
    int n;
    int reqs;
    val[0] = 12'd2000;
    val[1] = 12'd2000;
    val[2] = 12'd2000;
    val[3] = 12'd0;

    // Reset held, then idle with scanning disabled
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({adc_bus.adc_req, adc_bus.adc_ch, en_K, en_P, en_N, scan_done,
                               adc_err}), 0);
    rst = 1'b1;
    reqs = 0;
    repeat (40) begin
      @(negedge clk);
      if (adc_bus.adc_req) reqs++;
    end
    chk("idle_no_req", reqs, 0);
    chk("idle_outputs", int'({en_K, en_P, en_N, scan_done, adc_err}), 0);

    // N low for three rounds sets en_N on the third round
    push_round(100, 2000, 2000, 4'b0000);
    start_en = 1'b1;
    @(negedge clk);
    chk("req_latency_c1", int'(adc_bus.adc_req), 0);
    @(negedge clk);
    chk("req_latency_c2", int'(adc_bus.adc_req), 1);
    wait_done();
    round(100, 2000, 2000, 4'b0000);
    round(100, 2000, 2000, 4'b0001);

    // Inside the hysteresis band the flag holds; three recovered samples clear it
    repeat (5) round(520, 2000, 2000, 4'b0001);
    round(550, 2000, 2000, 4'b0001);
    round(550, 2000, 2000, 4'b0001);
    round(550, 2000, 2000, 4'b0000);

    // A non-low sample restarts the confirmation
    round(100, 2000, 2000, 4'b0000);
    round(100, 2000, 2000, 4'b0000);
    round(900, 2000, 2000, 4'b0000);
    round(100, 2000, 2000, 4'b0000);
    round(100, 2000, 2000, 4'b0000);

    // Set en_P, then time out on channel 1
    round(2000, 100, 2000, 4'b0000);
    round(2000, 100, 2000, 4'b0000);
    round(2000, 100, 2000, 4'b0010);
    mute_ch = 1;
    push_round(2000, 100, 2000, 4'b1010);
    n = 0;
    while (!(adc_bus.adc_req && adc_bus.adc_ch == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (adc_bus.adc_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 8);
    chk("timeout_err_set", int'(adc_err), 1);
    wait_done();
    mute_ch = -1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", int'(adc_err), 0);

    // Saturated recovery limit on K
    thr_K = 12'd4090;
    round(2000, 100, 100, 4'b0010);
    round(2000, 100, 100, 4'b0010);
    round(2000, 100, 100, 4'b0110);
    repeat (3) round(2000, 100, 4094, 4'b0110);
    round(2000, 100, 4095, 4'b0110);
    round(2000, 100, 4095, 4'b0110);
    round(2000, 100, 4095, 4'b0010);

    // Reset in the middle of a handshake, then a stray ack
    exp_ch_q.push_back(0);
    n = 0;
    while (!adc_bus.adc_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_req", int'(adc_bus.adc_req), 1);
    model_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_req_async", int'(adc_bus.adc_req), 0);
    chk("reset_flags_async", int'({en_K, en_P, en_N, adc_err}), 0);
    start_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    adc_bus.adc_ack  = 1'b1;
    adc_bus.adc_data = 12'd100;
    repeat (3) @(negedge clk);
    adc_bus.adc_ack = 1'b0;
    reqs = 0;
    repeat (30) begin
      @(negedge clk);
      if (adc_bus.adc_req || scan_done) reqs++;
    end
    chk("late_ack_ignored", reqs, 0);
    chk("late_ack_flags", int'({en_K, en_P, en_N, adc_err}), 0);

    chk("ch_queue_drained", exp_ch_q.size(), 0);
    chk("flag_queue_drained", exp_flag_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
